tacc: RTL and testbench

Streaming half-precision floating-point accumulator that sits directly downstream of the `tmult` multiplier. It consumes the multiplier's result stream and sums each `tlast`-delimited packet of products into one value, forming the reduction half of a dot-product datapath. The block is iterative, with one shared add/normalise/round datapath. It emits one sum per packet and sticky exception flags on the same valid/ready output.

---
 rtl/tfloat_pkg.sv | 46 ++++
 rtl/tfp_norm_round.sv | 73 +++++++
 rtl/tacc.sv | 193 +++++++++++++++++++
 tb/tb_tacc.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/tfloat_pkg.sv
// Shared definitions for the tfloat datapath blocks (tmult, tacc).
// Holds the accumulator FSM state enum, flag bit indices, width helpers
// parameterised by exponent/fraction width, and the special-value encodings.
package tfloat_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_OUT
  } state_e;

  localparam int unsigned FLAG_INVALID   = 0;
  localparam int unsigned FLAG_OVERFLOW  = 1;
  localparam int unsigned FLAG_UNDERFLOW = 2;

  // Exponent bias for an exp_w-bit exponent field.
  function automatic int unsigned f_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // Mantissa datapath: carry + hidden + fraction + guard/round/sticky.
  function automatic int unsigned f_man_w(input int unsigned fra_w);
    return fra_w + 5;
  endfunction

  // Alignment shift beyond this leaves only sticky information.
  function automatic int unsigned f_sat_shift(input int unsigned fra_w);
    return fra_w + 4;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  function automatic logic [31:0] f_qnan(input int unsigned exp_w, input int unsigned fra_w);
    return (((32'd1 << exp_w) - 32'd1) << fra_w) | (32'd1 << (fra_w - 1));
  endfunction

  // Positive infinity magnitude (sign bit excluded).
  function automatic logic [31:0] f_inf(input int unsigned exp_w, input int unsigned fra_w);
    return ((32'd1 << exp_w) - 32'd1) << fra_w;
  endfunction

  localparam logic [15:0] QNAN_H = 16'h7E00;
  localparam logic [15:0] INF_H  = 16'h7C00;

endpackage

// File: rtl/tfp_norm_round.sv
// Combinational normalise and round-to-nearest-even stage.
// Ports:
//   i_sign  - result sign
//   i_exp   - biased exponent of the hidden-bit position of i_man
//   i_man   - mantissa {carry, hidden, fraction, guard, round, sticky}
//   o_res   - packed half-precision style result (flushed/saturated)
//   o_ovf   - rounded exponent reached all ones; o_res is signed infinity
//   o_unf   - nonzero result below minimum normal; o_res is signed zero
module tfp_norm_round
  import tfloat_pkg::*;
#(
  parameter int unsigned EXP = 5,
  parameter int unsigned FRA = 10
) (
  input  logic               i_sign,
  input  logic [EXP-1:0]     i_exp,
  input  logic [FRA+4:0]     i_man,
  output logic [EXP+FRA:0]   o_res,
  output logic               o_ovf,
  output logic               o_unf
);

  localparam int unsigned MW   = f_man_w(FRA);
  localparam int unsigned LW   = $clog2(MW);
  localparam int unsigned EW   = EXP + 2;
  localparam int unsigned EMAX = (32'd1 << EXP) - 32'd1;
  localparam logic [EXP+FRA-1:0] INF_MAG = (EXP + FRA)'(f_inf(EXP, FRA));

  logic [LW-1:0]  w_lzc;
  logic [MW-1:0]  w_shift;
  logic [EW-1:0]  w_exp_n;
  logic [EW-1:0]  w_exp_r;
  logic           w_up;
  logic [FRA+1:0] w_rnd;
  logic           w_carry;
  logic [FRA-1:0] w_frac;

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    w_lzc = '0;
    for (int i = 0; i < int'(MW); i++) begin
      if (i_man[i]) w_lzc = LW'(int'(MW) - 1 - i);
    end
  end

  always_comb begin
    w_shift = i_man << w_lzc;
    // Leading one moves to the carry position, so the exponent gains one and
    // loses one per leading zero.
    w_exp_n = {2'b00, i_exp} + EW'(1) - EW'(w_lzc);
    w_up    = w_shift[3] & ((|w_shift[2:0]) | w_shift[4]);
    w_rnd   = {1'b0, w_shift[MW-1:4]} + (FRA + 2)'(w_up);
    w_carry = w_rnd[FRA+1];
    w_frac  = w_carry ? w_rnd[FRA:1] : w_rnd[FRA-1:0];
    w_exp_r = w_exp_n + EW'(w_carry);
  end

  always_comb begin
    o_res = {i_sign, w_exp_r[EXP-1:0], w_frac};
    o_ovf = 1'b0;
    o_unf = 1'b0;
    if (i_man == '0) begin
      o_res = {i_sign, {(EXP + FRA){1'b0}}};
    end else if ($signed(w_exp_r) >= $signed(EW'(EMAX))) begin
      o_res = {i_sign, INF_MAG};
      o_ovf = 1'b1;
    end else if ($signed(w_exp_r) <= $signed(EW'(0))) begin
      o_res = {i_sign, {(EXP + FRA){1'b0}}};
      o_unf = 1'b1;
    end
  end

endmodule

// File: rtl/tacc.sv
// Streaming floating-point packet accumulator (reduction half of a dot product).
// Sums each tlast-delimited packet with one iterative align/add/normalise datapath
// (4 cycles per operand) and emits the sum plus sticky exception flags.
// Ports:
//   aclk, areset                 - clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tready   - operand stream, s_axis_tlast ends a packet
//   m_axis_result_tdata/tvalid/tready - per-packet sum
//   flag                         - {underflow, overflow, invalid}, valid with result
module tacc
  import tfloat_pkg::*;
#(
  parameter int unsigned EXP = 5,
  parameter int unsigned FRA = 10
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic [EXP+FRA:0]   s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tlast,
  output logic [EXP+FRA:0]   m_axis_result_tdata,
  output logic               m_axis_result_tvalid,
  input  logic               m_axis_result_tready,
  output logic [2:0]         flag
);

  localparam int unsigned W   = EXP + FRA + 1;
  localparam int unsigned MW  = f_man_w(FRA);
  localparam int unsigned SAT = f_sat_shift(FRA);
  localparam logic [W-1:0] QNAN = W'(f_qnan(EXP, FRA));

  state_e         r_state;
  logic [W-1:0]   r_op;
  logic           r_last;
  logic [W-1:0]   r_acc;
  logic [2:0]     r_flag;
  logic           r_tvalid;
  logic           r_sign_a;
  logic           r_sign_b;
  logic [EXP-1:0] r_exp;
  logic [MW-1:0]  r_man_a;
  logic [MW-1:0]  r_man_b;
  logic           r_spec;
  logic           r_spec_inv;
  logic [W-1:0]   r_spec_val;
  logic [MW-1:0]  r_sum;
  logic           r_rsign;

  // Operand classification
  logic           w_a_nan, w_a_inf, w_a_zero, w_b_nan, w_b_inf, w_b_zero;
  logic [W-2:0]   w_a_mag, w_b_mag, w_big_mag, w_small_mag;
  logic           w_big_sign, w_small_sign;
  logic [MW-1:0]  w_big_man, w_small_man, w_small_sh, w_mask;
  logic [31:0]    w_diff, w_sh;
  logic           w_inv, w_spec;
  logic [W-1:0]   w_spec_val;
  logic [MW-1:0]  w_sum;
  logic           w_rsign;
  logic [W-1:0]   w_nr_res;
  logic           w_nr_ovf, w_nr_unf;

  always_comb begin
    w_a_nan  = (&r_acc[W-2:FRA]) & (|r_acc[FRA-1:0]);
    w_a_inf  = (&r_acc[W-2:FRA]) & ~(|r_acc[FRA-1:0]);
    w_a_zero = (r_acc[W-2:FRA] == '0);
    w_b_nan  = (&r_op[W-2:FRA]) & (|r_op[FRA-1:0]);
    w_b_inf  = (&r_op[W-2:FRA]) & ~(|r_op[FRA-1:0]);
    w_b_zero = (r_op[W-2:FRA] == '0);
    // Subnormals are flushed to signed zero before any comparison.
    w_a_mag  = w_a_zero ? '0 : r_acc[W-2:0];
    w_b_mag  = w_b_zero ? '0 : r_op[W-2:0];

    if (w_a_mag >= w_b_mag) begin
      w_big_mag    = w_a_mag;
      w_big_sign   = r_acc[W-1];
      w_small_mag  = w_b_mag;
      w_small_sign = r_op[W-1];
    end else begin
      w_big_mag    = w_b_mag;
      w_big_sign   = r_op[W-1];
      w_small_mag  = w_a_mag;
      w_small_sign = r_acc[W-1];
    end

    w_big_man   = {1'b0, |w_big_mag[W-2:FRA], w_big_mag[FRA-1:0], 3'b000};
    w_small_man = {1'b0, |w_small_mag[W-2:FRA], w_small_mag[FRA-1:0], 3'b000};
    w_diff      = 32'(w_big_mag[W-2:FRA]) - 32'(w_small_mag[W-2:FRA]);
    w_sh        = (w_diff > SAT) ? SAT : w_diff;
    w_mask      = (MW'(1) << w_sh) - MW'(1);
    w_small_sh  = (w_small_man >> w_sh) | MW'(|(w_small_man & w_mask));

    w_inv      = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (r_acc[W-1] ^ r_op[W-1]));
    w_spec     = w_inv | w_a_inf | w_b_inf;
    w_spec_val = w_inv ? QNAN : (w_a_inf ? r_acc : r_op);
  end

  // The larger magnitude is always first, so subtraction never goes negative.
  always_comb begin
    w_sum   = (r_sign_a == r_sign_b) ? (r_man_a + r_man_b) : (r_man_a - r_man_b);
    w_rsign = ((w_sum == '0) && (r_sign_a != r_sign_b)) ? 1'b0 : r_sign_a;
  end

  tfp_norm_round #(
    .EXP (EXP),
    .FRA (FRA)
  ) u_norm_round (
    .i_sign (r_rsign),
    .i_exp  (r_exp),
    .i_man  (r_sum),
    .o_res  (w_nr_res),
    .o_ovf  (w_nr_ovf),
    .o_unf  (w_nr_unf)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_last     <= 1'b0;
      r_acc      <= '0;
      r_flag     <= '0;
      r_tvalid   <= 1'b0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_exp      <= '0;
      r_man_a    <= '0;
      r_man_b    <= '0;
      r_spec     <= 1'b0;
      r_spec_inv <= 1'b0;
      r_spec_val <= '0;
      r_sum      <= '0;
      r_rsign    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (s_axis_tvalid) begin
            r_op    <= s_axis_tdata;
            r_last  <= s_axis_tlast;
            r_state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          r_sign_a   <= w_big_sign;
          r_sign_b   <= w_small_sign;
          r_exp      <= w_big_mag[W-2:FRA];
          r_man_a    <= w_big_man;
          r_man_b    <= w_small_sh;
          r_spec     <= w_spec;
          r_spec_inv <= w_inv;
          r_spec_val <= w_spec_val;
          r_state    <= S_ADD;
        end
        S_ADD: begin
          r_sum   <= w_sum;
          r_rsign <= w_rsign;
          r_state <= S_NORM;
        end
        S_NORM: begin
          if (r_spec) begin
            r_acc               <= r_spec_val;
            r_flag[FLAG_INVALID] <= r_flag[FLAG_INVALID] | r_spec_inv;
          end else begin
            r_acc                  <= w_nr_res;
            r_flag[FLAG_OVERFLOW]  <= r_flag[FLAG_OVERFLOW] | w_nr_ovf;
            r_flag[FLAG_UNDERFLOW] <= r_flag[FLAG_UNDERFLOW] | w_nr_unf;
          end
          if (r_last) begin
            r_tvalid <= 1'b1;
            r_state  <= S_OUT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_OUT: begin
          if (m_axis_result_tready) begin
            r_acc    <= '0;
            r_flag   <= '0;
            r_tvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Gated by areset so tready is low during reset yet high in the first idle cycle.
  assign s_axis_tready        = (r_state == S_IDLE) && !areset;
  assign m_axis_result_tvalid = r_tvalid;
  assign m_axis_result_tdata  = r_acc;
  assign flag                 = r_flag;

endmodule

// File: tb/tb_tacc.sv
// Directed bench for tacc: hand-computed half-precision sums, timing, backpressure, reset.
module tb_tacc;

  localparam int unsigned EXP = 5;
  localparam int unsigned FRA = 10;
  localparam int unsigned W   = EXP + FRA + 1;

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic [W-1:0] s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;
  logic [W-1:0] m_axis_result_tdata;
  logic         m_axis_result_tvalid;
  logic         m_axis_result_tready = 1'b0;
  logic [2:0]   flag;

  int n_vec = 0;
  int n_bad = 0;

  always #5 aclk = ~aclk;

  tacc #(
    .EXP (EXP),
    .FRA (FRA)
  ) u_dut (
    .aclk                 (aclk),
    .areset               (areset),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tready        (s_axis_tready),
    .s_axis_tlast         (s_axis_tlast),
    .m_axis_result_tdata  (m_axis_result_tdata),
    .m_axis_result_tvalid (m_axis_result_tvalid),
    .m_axis_result_tready (m_axis_result_tready),
    .flag                 (flag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Offer one operand; optionally count cycles until tready or tvalid returns (expect 3).
  task automatic send(input logic [W-1:0] d, input logic last, input bit wait_done,
                      input string tag);
    bit ok;
    int n;
    ok            = 1'b0;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (s_axis_tready) ok = 1'b1;
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check({tag, " accept"}, 32'(ok), 32'd1);
    if (wait_done) begin
      n = 0;
      while (!(s_axis_tready || m_axis_result_tvalid) && n < 20) begin
        tick();
        n++;
      end
      check({tag, " latency"}, 32'(n), 32'd3);
    end
  endtask

  task automatic get_result(input logic [W-1:0] expd, input logic [2:0] expf, input string tag);
    int n;
    n = 0;
    while (!m_axis_result_tvalid && n < 20) begin
      tick();
      n++;
    end
    check({tag, " valid"}, 32'(m_axis_result_tvalid), 32'd1);
    check({tag, " data"}, 32'(m_axis_result_tdata), 32'(expd));
    check({tag, " flag"}, 32'(flag), 32'(expf));
    m_axis_result_tready = 1'b1;
    tick();
    m_axis_result_tready = 1'b0;
    check({tag, " release"}, 32'({m_axis_result_tvalid, s_axis_tready}), 32'b01);
  endtask

  task automatic pkt2(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] expd,
                      input logic [2:0] expf, input string tag);
    send(a, 1'b0, 1'b1, {tag, " op0"});
    send(b, 1'b1, 1'b1, {tag, " op1"});
    get_result(expd, expf, tag);
  endtask

  initial begin
    // Reset values
    areset = 1'b1;
    tick();
    tick();
    check("reset outputs", 32'({s_axis_tready, m_axis_result_tvalid, m_axis_result_tdata, flag}),
          32'd0);
    areset = 1'b0;
    #1;
    check("idle after reset", 32'(s_axis_tready), 32'd1);

    // Basic sum, latency checked inside send
    pkt2(16'h3C00, 16'h4000, 16'h4200, 3'b000, "basic");

    // Four ones
    send(16'h3C00, 1'b0, 1'b1, "four e0");
    send(16'h3C00, 1'b0, 1'b1, "four e1");
    send(16'h3C00, 1'b0, 1'b1, "four e2");
    send(16'h3C00, 1'b1, 1'b1, "four e3");
    get_result(16'h4400, 3'b000, "four");

    pkt2(16'h3C00, 16'hBC00, 16'h0000, 3'b000, "zero sum");

    // Rounding
    pkt2(16'h6800, 16'h3C00, 16'h6800, 3'b000, "rne tie");
    pkt2(16'h6800, 16'h4200, 16'h6802, 3'b000, "rne up");
    pkt2(16'h6400, 16'h3C00, 16'h6401, 3'b000, "exact");

    // Exceptions
    pkt2(16'h7BFF, 16'h7BFF, 16'h7C00, 3'b010, "overflow");
    pkt2(16'h7C00, 16'hFC00, 16'h7E00, 3'b001, "inf-inf");
    pkt2(16'h0400, 16'h8001, 16'h0400, 3'b000, "subnormal");
    pkt2(16'h0400, 16'h8401, 16'h8000, 3'b100, "underflow");

    // Single operand is passed through normalised
    send(16'hC500, 1'b1, 1'b1, "single");
    get_result(16'hC500, 3'b000, "single");

    // Backpressure on a flagged result
    send(16'h7BFF, 1'b0, 1'b1, "bp op0");
    send(16'h7BFF, 1'b1, 1'b1, "bp op1");
    for (int i = 0; i < 10; i++) begin
      check("bp hold",
            32'({m_axis_result_tvalid, s_axis_tready, m_axis_result_tdata, flag}),
            32'({1'b1, 1'b0, 16'h7C00, 3'b010}));
      tick();
    end
    get_result(16'h7C00, 3'b010, "bp");
    send(16'h4000, 1'b1, 1'b1, "bp next");
    get_result(16'h4000, 3'b000, "bp next");

    // Reset during S_ADD of the second element
    send(16'h3C00, 1'b0, 1'b1, "rst op0");
    send(16'h4000, 1'b0, 1'b0, "rst op1");
    tick();
    areset = 1'b1;
    tick();
    check("mid reset outputs",
          32'({s_axis_tready, m_axis_result_tvalid, m_axis_result_tdata, flag}), 32'd0);
    areset = 1'b0;
    #1;
    check("mid reset idle", 32'(s_axis_tready), 32'd1);
    send(16'h4000, 1'b1, 1'b1, "post rst");
    get_result(16'h4000, 3'b000, "post rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
